// File: rtl/dflow_gen_pkg.sv
// Shared types and default widths for the dflow packet generator.
package dflow_gen_pkg;

  localparam int unsigned MEM_ADDR_WIDTH_DEF  = 19;
  localparam int unsigned MEM_DATA_WIDTH_DEF  = 144;
  localparam int unsigned FIFO_DATA_WIDTH_DEF = 144;
  localparam int unsigned MAX_OUTSTANDING_DEF = 16;
  localparam int unsigned LOOP_WIDTH_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } replay_state_t;

endpackage

// File: rtl/rd_credit_ctr.sv
// Tracks read commands in flight. A flush moves any in-flight reads into a discard
// count so that their late returns can be recognised and dropped.
module rd_credit_ctr #(
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              incr,
  input  logic                              decr,
  input  logic                              flush,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              can_issue_c,
  output logic                              discarding_c
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [CW-1:0] discard_cnt;
  logic          decr_live_c;

  assign discarding_c = (discard_cnt != '0);
  assign can_issue_c  = (outstanding < CW'(MAX_OUTSTANDING));
  assign decr_live_c  = decr && !discarding_c;

  // Returns are consumed by the discard count first, since they arrive in issue order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      discard_cnt <= '0;
    end else if (flush) begin
      outstanding <= '0;
      discard_cnt <= discard_cnt + outstanding - CW'(decr);
    end else begin
      if (decr && discarding_c) discard_cnt <= discard_cnt - CW'(1);
      case ({incr, decr_live_c})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: rtl/mem_to_fifo.sv
// Replay reader: streams the stored record window from memory into the packet-builder
// FIFO, looping over the window a programmable number of times.
module mem_to_fifo
  import dflow_gen_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH  = MEM_ADDR_WIDTH_DEF,
  parameter int unsigned MEM_DATA_WIDTH  = MEM_DATA_WIDTH_DEF,
  parameter int unsigned FIFO_DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int unsigned LOOP_WIDTH      = LOOP_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       app_rd_cmd,
  output logic [MEM_ADDR_WIDTH-1:0]  app_rd_addr,
  input  logic                       app_rd_valid,
  input  logic [MEM_DATA_WIDTH-1:0]  app_rd_data,
  output logic                       fifo_wr_en,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_data,
  input  logic                       fifo_prog_full,
  input  logic [MEM_ADDR_WIDTH-1:0]  dflow_addr_low,
  input  logic [MEM_ADDR_WIDTH-1:0]  dflow_mem_high,
  input  logic [LOOP_WIDTH-1:0]      replay_loops,
  input  logic                       start_replay,
  input  logic                       cal_done,
  input  logic                       sw_rst,
  output logic                       replay_busy,
  output logic                       replay_done,
  output logic [LOOP_WIDTH-1:0]      loops_done
);

  localparam int unsigned MAW = MEM_ADDR_WIDTH;
  localparam int unsigned LW  = LOOP_WIDTH;
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING) + 1;

  replay_state_t  state, state_nxt;
  logic [MAW-1:0] rd_ptr, end_r;
  logic           done_flag;
  logic [CW-1:0]  outstanding;
  logic           can_issue_c, discarding_c;
  logic           issue_c, start_c;
  logic           empty_c, last_c, pass_done_c;
  logic [LW-1:0]  loops_inc_c;

  assign empty_c     = (dflow_mem_high == dflow_addr_low);
  assign last_c      = (rd_ptr == (end_r - MAW'(1)));
  assign loops_inc_c = (loops_done == '1) ? loops_done : loops_done + LW'(1);
  assign pass_done_c = last_c && (replay_loops != '0) && (loops_inc_c == replay_loops);

  rd_credit_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clk          (clk),
    .rst          (rst),
    .incr         (issue_c),
    .decr         (app_rd_valid),
    .flush        (sw_rst),
    .outstanding  (outstanding),
    .can_issue_c  (can_issue_c),
    .discarding_c (discarding_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         state <= IDLE;
    else if (sw_rst) state <= IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_replay && cal_done && !discarding_c) state_nxt = empty_c ? DONE : READ;
      READ:  if ((issue_c && pass_done_c) || !start_replay) state_nxt = DRAIN;
      DRAIN: if (outstanding == '0) state_nxt = done_flag ? DONE : IDLE;
      DONE:  if (!start_replay) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command decision; the credit count includes the command about to be presented.
  always_comb begin
    issue_c = 1'b0;
    start_c = 1'b0;
    if (state == READ)
      issue_c = start_replay && cal_done && !fifo_prog_full && can_issue_c && !sw_rst;
    if (state == IDLE && state_nxt != IDLE)
      start_c = 1'b1;
  end

  // Registered outputs, pointer and loop bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      app_rd_cmd  <= 1'b0;
      app_rd_addr <= '0;
      fifo_wr_en  <= 1'b0;
      fifo_data   <= '0;
      replay_busy <= 1'b0;
      replay_done <= 1'b0;
      loops_done  <= '0;
      done_flag   <= 1'b0;
      end_r       <= '0;
      rd_ptr      <= '0;  // reloaded from the window base at every start
    end else if (sw_rst) begin
      app_rd_cmd  <= 1'b0;
      app_rd_addr <= '0;
      fifo_wr_en  <= 1'b0;
      fifo_data   <= '0;
      replay_busy <= 1'b0;
      replay_done <= 1'b0;
      loops_done  <= '0;
      done_flag   <= 1'b0;
      end_r       <= '0;
      rd_ptr      <= dflow_addr_low;
    end else begin
      app_rd_cmd  <= issue_c;
      if (issue_c) app_rd_addr <= rd_ptr;
      fifo_wr_en  <= app_rd_valid && !discarding_c;
      fifo_data   <= FIFO_DATA_WIDTH'(app_rd_data);
      replay_busy <= (state_nxt == READ) || (state_nxt == DRAIN);
      replay_done <= (state_nxt == DONE);
      if (start_c) begin
        end_r      <= dflow_mem_high;
        rd_ptr     <= dflow_addr_low;
        loops_done <= '0;
        done_flag  <= 1'b0;
      end else if (issue_c) begin
        if (last_c) begin
          rd_ptr     <= dflow_addr_low;
          loops_done <= loops_inc_c;
          if (pass_done_c) done_flag <= 1'b1;
        end else begin
          rd_ptr <= rd_ptr + MAW'(1);
        end
      end
    end
  end

endmodule
